lcd_text_frame_ctrl: RTL

//  Parametrised HD44780-class character-LCD controller with a host-writable text buffer.

---
 rtl/lcd_text_frame_ctrl_if.sv | 25 ++
 rtl/lcd_text_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_frame_ctrl_if.sv
// Host write port and LCD pin bundle for lcd_text_frame_ctrl.
// The master side drives buffer writes; the slave side is the controller driving the LCD pins.
interface lcd_text_frame_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic              init_done;
  logic              frame_done;
  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [7:0]        lcd_data;

  modport master (
    output wr_en, wr_addr, wr_char,
    input  init_done, frame_done, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_char,
    output init_done, frame_done, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

// File: rtl/lcd_text_frame_ctrl.sv
// HD44780-class character LCD controller: one-shot init sequence, then endless refresh from a text buffer.
// Define LCD_BLINK_EN for a blinking cursor parked at the last accepted write position.
module lcd_text_frame_ctrl #(
  parameter int COLS          = 16,
  parameter int ROWS          = 2,
  parameter int TICK_DIV      = 5,
  parameter int PWRUP_TICKS   = 70,
  parameter int CMD_TICKS     = 30,
  parameter int CLR_TICKS     = 200,
  parameter int CHAR_TICKS    = 1,
  parameter int REFRESH_TICKS = 400
) (
  input logic             clk,
  input logic             reset,
  lcd_text_frame_ctrl_if.slave bus
);

  localparam int NCHAR     = ROWS * COLS;
  localparam int ADDR_W    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_A     = (PWRUP_TICKS > CMD_TICKS) ? PWRUP_TICKS : CMD_TICKS;
  localparam int MAX_B     = (CLR_TICKS > CHAR_TICKS) ? CLR_TICKS : CHAR_TICKS;
  localparam int MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_TICKS = (MAX_C > REFRESH_TICKS) ? MAX_C : REFRESH_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  typedef enum logic [3:0] {
    S_PWRUP,
    S_FUNC_SET,
    S_DISP_CTRL,
    S_ENTRY,
    S_CLEAR,
    S_SET_ADDR,
    S_CHAR,
    S_CURSOR,
    S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    PH_T0,
    PH_T1,
    PH_T2,
    PH_WAIT
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              e_q, e_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              init_done_q, init_done_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              wr_ok;
  logic              xfer_end;
  logic [ADDR_W-1:0] char_idx;
  logic [7:0]        xfer_byte;
  logic [CNT_W-1:0]  wait_len;

  // Contents survive reset; only configuration loads the blank-screen pattern.
  logic [7:0] buf_mem [NCHAR] = '{default: 8'h20};

  assign tick     = (div_q == DIV_W'(TICK_DIV - 1));
  assign wr_ok    = bus.wr_en && (int'(bus.wr_addr) < NCHAR);
  assign char_idx = ADDR_W'(col_q) + (row_q ? ADDR_W'(COLS) : ADDR_W'(0));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      buf_mem[bus.wr_addr] <= bus.wr_char;
    end
  end

`ifdef LCD_BLINK_EN
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [7:0]        cursor_cmd;

  always_comb begin
    cursor_d = wr_ok ? bus.wr_addr : cursor_q;
    if (int'(cursor_q) >= COLS) begin
      cursor_cmd = 8'hC0 + 8'(int'(cursor_q) - COLS);
    end else begin
      cursor_cmd = 8'h80 + 8'(cursor_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_q <= '0;
    end else begin
      cursor_q <= cursor_d;
    end
  end
`endif

  always_comb begin
    xfer_byte = 8'h00;
    wait_len  = CNT_W'(CHAR_TICKS);
    case (state_q)
      S_FUNC_SET: begin
        xfer_byte = (ROWS == 2) ? 8'h38 : 8'h30;
        wait_len  = CNT_W'(CMD_TICKS);
      end
      S_DISP_CTRL: begin
`ifdef LCD_BLINK_EN
        xfer_byte = 8'h0F;
`else
        xfer_byte = 8'h0C;
`endif
        wait_len  = CNT_W'(CMD_TICKS);
      end
      S_ENTRY: begin
        xfer_byte = 8'h06;
        wait_len  = CNT_W'(CMD_TICKS);
      end
      S_CLEAR: begin
        xfer_byte = 8'h01;
        wait_len  = CNT_W'(CLR_TICKS);
      end
      S_SET_ADDR: xfer_byte = row_q ? 8'hC0 : 8'h80;
      S_CHAR:     xfer_byte = buf_mem[char_idx];
`ifdef LCD_BLINK_EN
      S_CURSOR:   xfer_byte = cursor_cmd;
`endif
      default:    xfer_byte = 8'h00;
    endcase
  end

  // Every bus step happens on a tick; transfer states walk T0/T1/T2 then the post-transfer wait.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    row_d        = row_q;
    col_d        = col_q;
    e_d          = e_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    xfer_end     = 1'b0;

    if (tick) begin
      case (state_q)
        S_PWRUP: begin
          if (cnt_q == CNT_W'(PWRUP_TICKS - 1)) begin
            state_d = S_FUNC_SET;
            phase_d = PH_T0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (cnt_q == CNT_W'(REFRESH_TICKS - 1)) begin
            state_d = S_SET_ADDR;
            phase_d = PH_T0;
            cnt_d   = '0;
            row_d   = 1'b0;
            col_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          case (phase_q)
            PH_T0: begin
              rs_d    = (state_q == S_CHAR);
              data_d  = xfer_byte;
              e_d     = 1'b0;
              phase_d = PH_T1;
            end
            PH_T1: begin
              e_d     = 1'b1;
              phase_d = PH_T2;
            end
            PH_T2: begin
              e_d   = 1'b0;
              cnt_d = '0;
              if (wait_len == '0) begin
                xfer_end = 1'b1;
              end else begin
                phase_d = PH_WAIT;
              end
            end
            default: begin
              if (cnt_q == wait_len - CNT_W'(1)) begin
                xfer_end = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          endcase
        end
      endcase

      if (xfer_end) begin
        phase_d = PH_T0;
        cnt_d   = '0;
        case (state_q)
          S_FUNC_SET:  state_d = S_DISP_CTRL;
          S_DISP_CTRL: state_d = S_ENTRY;
          S_ENTRY:     state_d = S_CLEAR;
          S_CLEAR: begin
            state_d     = S_SET_ADDR;
            init_done_d = 1'b1;
            row_d       = 1'b0;
            col_d       = '0;
          end
          S_SET_ADDR:  state_d = S_CHAR;
          S_CHAR: begin
            if (col_q == COL_W'(COLS - 1)) begin
              if (ROWS == 2 && !row_q) begin
                row_d   = 1'b1;
                col_d   = '0;
                state_d = S_SET_ADDR;
              end else begin
`ifdef LCD_BLINK_EN
                state_d = S_CURSOR;
`else
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
`endif
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          default: begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        endcase
      end
    end
  end

  // Reset aborts any transfer in flight and forces a full re-init from power-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PWRUP;
      phase_q      <= PH_T0;
      cnt_q        <= '0;
      div_q        <= '0;
      row_q        <= 1'b0;
      col_q        <= '0;
      e_q          <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      row_q        <= row_d;
      col_q        <= col_d;
      e_q          <= e_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.lcd_e      = e_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_data   = data_q;
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;

endmodule
